// File: rtl/shiftreg_pkg.sv
// Shared definitions for the elastic shift register: occupancy counter width
// and the counter update encoding.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shiftreg_elastic_stage.sv
// One stage of the elastic shift register: a valid bit plus payload register
// that loads from upstream whenever it is empty or its downstream neighbour frees.
module shiftreg_elastic_stage #(
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_vld_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 down_free_i,
  output logic                 vld_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 free_o
);

  logic                 vld_q, vld_d;
  logic [DataWidth-1:0] data_q, data_d;

  assign free_o = !vld_q || down_free_i;

  // Payload only moves with a valid word, so an emptied stage keeps its last value.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (free_o) begin
      vld_d = in_vld_i;
      if (in_vld_i) data_d = in_data_i;
    end
    if (flush_i) begin
      vld_d  = 1'b0;
      data_d = data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/shiftreg_elastic.sv
// Depth-stage elastic shift register with valid/ready on both sides, bubble
// collapsing, synchronous flush and a registered occupancy count.
module shiftreg_elastic
  import shiftreg_pkg::*;
#(
  parameter int Depth     = 4,
  parameter int DataWidth = 32,
  parameter int CntWidth  = cnt_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  logic [Depth-1:0]     vld;
  logic [DataWidth-1:0] data [Depth];
  logic                 head_free;

  // The free chain runs tail to head through per-stage signals so the ready
  // path stays purely combinational from ready_i to ready_o.
  for (genvar k = 0; k < Depth; k++) begin : g_stage
    logic                 free_w;
    logic                 in_vld;
    logic [DataWidth-1:0] in_data;
    logic                 down_free;

    if (k == 0) begin : g_head
      assign in_vld  = valid_i;
      assign in_data = data_i;
    end else begin : g_body
      assign in_vld  = vld[k-1];
      assign in_data = data[k-1];
    end

    if (k == Depth - 1) begin : g_tail
      assign down_free = ready_i;
    end else begin : g_link
      assign down_free = g_stage[k+1].free_w;
    end

    shiftreg_elastic_stage #(
      .DataWidth (DataWidth)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_vld_i    (in_vld),
      .in_data_i   (in_data),
      .down_free_i (down_free),
      .vld_o       (vld[k]),
      .data_o      (data[k]),
      .free_o      (free_w)
    );
  end

  assign head_free = g_stage[0].free_w;

  // Flush blocks both handshakes for the cycle it is asserted.
  assign ready_o = head_free && !flush_i;
  assign valid_o = vld[Depth-1] && !flush_i;
  assign data_o  = data[Depth-1];

  logic          push, pop;
  cnt_op_e       cnt_op;
  logic [CntWidth-1:0] count_q, count_d;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_comb begin
    cnt_op = CNT_HOLD;
    if (flush_i)            cnt_op = CNT_CLR;
    else if (push && !pop)  cnt_op = CNT_INC;
    else if (pop && !push)  cnt_op = CNT_DEC;
  end

  always_comb begin
    count_d = count_q;
    case (cnt_op)
      CNT_INC: count_d = count_q + CntWidth'(1);
      CNT_DEC: count_d = count_q - CntWidth'(1);
      CNT_CLR: count_d = '0;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntWidth'(Depth));

endmodule

// File: tb/tb_shiftreg_elastic.sv
// Bench for shiftreg_elastic: directed scenarios on a Depth=4 instance and a
// randomized run on Depth 1/2/4/7 against a positional queue model.
module tb_shiftreg_elastic;
  import shiftreg_pkg::*;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int M  = 2;

  function automatic int dep(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, vin;
  logic [DW-1:0] din;
  logic [NI-1:0] rdy, rdo, vo, eo, fo;
  logic [DW-1:0] dout [NI];
  logic [7:0]    cnt  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = dep(g);
    logic [cnt_width(D)-1:0] c;
    shiftreg_elastic #(
      .Depth     (D),
      .DataWidth (DW)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .valid_i (vin),
      .ready_o (rdo[g]),
      .data_i  (din),
      .valid_o (vo[g]),
      .ready_i (rdy[g]),
      .data_o  (dout[g]),
      .count_o (c),
      .empty_o (eo[g]),
      .full_o  (fo[g])
    );
    assign cnt[g] = 8'(c);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; din = '0; rdy = '0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_tests++; if (vo[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", i, vo[i]); end
      n_tests++; if (cnt[i] !== 8'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", i, cnt[i]); end
      n_tests++; if (eo[i] !== 1'b1) begin n_fail++; $display("FAIL reset_empty[%0d]: got %b want 1", i, eo[i]); end
      n_tests++; if (fo[i] !== 1'b0) begin n_fail++; $display("FAIL reset_full[%0d]: got %b want 0", i, fo[i]); end
      n_tests++; if (rdo[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", i, rdo[i]); end
      n_tests++; if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", i, dout[i]); end
    end
  endtask

  // Four back-to-back words with ready_i held high; expects them on cycles 4..7.
  task automatic run_stream(input logic [DW-1:0] base, input string tag);
    int maxc = 0;
    logic exp_v;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      rdy = '1; vin = (t < 4); din = base + DW'(t);
      #1;
      exp_v = (t >= 4 && t < 8);
      if (t < 4) begin
        n_tests++; if (rdo[M] !== 1'b1) begin n_fail++; $display("FAIL %s_ready t=%0d: got %b want 1", tag, t, rdo[M]); end
      end
      n_tests++; if (vo[M] !== exp_v) begin n_fail++; $display("FAIL %s_valid t=%0d: got %b want %b", tag, t, vo[M], exp_v); end
      if (exp_v) begin
        n_tests++; if (dout[M] !== base + DW'(t - 4)) begin n_fail++; $display("FAIL %s_data t=%0d: got %h want %h", tag, t, dout[M], base + DW'(t - 4)); end
      end
      if (int'(cnt[M]) > maxc) maxc = int'(cnt[M]);
    end
    vin = 1'b0;
    n_tests++; if (maxc != 4) begin n_fail++; $display("FAIL %s_peak_count: got %0d want 4", tag, maxc); end
    n_tests++; if (eo[M] !== 1'b1) begin n_fail++; $display("FAIL %s_drained: got %b want 1", tag, eo[M]); end
  endtask

  task automatic test_stream();
    run_stream(32'hDEAD0000, "stream");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp [5];
    exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h5};
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      rdy = (t >= 6) ? '1 : '0;
      vin = (t <= 6);
      din = (t < 4) ? 32'hA0 + DW'(t) : 32'h5;
      #1;
      if (t < 4) begin
        n_tests++; if (rdo[M] !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready t=%0d: got %b want 1", t, rdo[M]); end
      end
      if (t == 4 || t == 5) begin
        n_tests++; if (fo[M] !== 1'b1) begin n_fail++; $display("FAIL bp_full t=%0d: got %b want 1", t, fo[M]); end
        n_tests++; if (rdo[M] !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready t=%0d: got %b want 0", t, rdo[M]); end
        n_tests++; if (cnt[M] !== 8'd4) begin n_fail++; $display("FAIL bp_stall_count t=%0d: got %0d want 4", t, cnt[M]); end
      end
      if (t == 6) begin
        n_tests++; if (rdo[M] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", rdo[M]); end
      end
      if (t == 7) begin
        n_tests++; if (cnt[M] !== 8'd4) begin n_fail++; $display("FAIL bp_pushpop_count: got %0d want 4", cnt[M]); end
      end
      if (t >= 6 && t <= 10) begin
        n_tests++; if (vo[M] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid t=%0d: got %b want 1", t, vo[M]); end
        n_tests++; if (dout[M] !== exp[t-6]) begin n_fail++; $display("FAIL bp_out_data t=%0d: got %h want %h", t, dout[M], exp[t-6]); end
      end
      if (t == 11) begin
        n_tests++; if (vo[M] !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b want 0", vo[M]); end
        n_tests++; if (cnt[M] !== 8'd0) begin n_fail++; $display("FAIL bp_end_count: got %0d want 0", cnt[M]); end
      end
    end
    vin = 1'b0;
  endtask

  task automatic test_bubbles();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      rdy = (t >= 6) ? '1 : '0;
      vin = (t < 6) && (t % 2 == 0);
      din = 32'hB0 + DW'(t / 2);
      #1;
      if (t == 5) begin
        n_tests++; if (rdo[M] !== 1'b1) begin n_fail++; $display("FAIL bub_gap_ready: got %b want 1", rdo[M]); end
      end
      if (t == 6) begin
        n_tests++; if (cnt[M] !== 8'd3) begin n_fail++; $display("FAIL bub_count: got %0d want 3", cnt[M]); end
      end
      if (t >= 6 && t <= 8) begin
        n_tests++; if (vo[M] !== 1'b1) begin n_fail++; $display("FAIL bub_valid t=%0d: got %b want 1", t, vo[M]); end
        n_tests++; if (dout[M] !== 32'hB0 + DW'(t - 6)) begin n_fail++; $display("FAIL bub_data t=%0d: got %h want %h", t, dout[M], 32'hB0 + DW'(t - 6)); end
      end
      if (t == 9) begin
        n_tests++; if (vo[M] !== 1'b0) begin n_fail++; $display("FAIL bub_end_valid: got %b want 0", vo[M]); end
      end
    end
    vin = 1'b0;
  endtask

  task automatic test_flush();
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      rdy   = (t >= 6) ? '1 : '0;
      flush = (t == 4);
      vin   = (t < 3) || (t == 4);
      din   = (t == 4) ? 32'hBAD : 32'hC0 + DW'(t);
      #1;
      if (t == 4) begin
        n_tests++; if (cnt[M] !== 8'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", cnt[M]); end
        n_tests++; if (rdo[M] !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", rdo[M]); end
        n_tests++; if (vo[M] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", vo[M]); end
      end
      if (t == 5) begin
        n_tests++; if (cnt[M] !== 8'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", cnt[M]); end
        n_tests++; if (eo[M] !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", eo[M]); end
        n_tests++; if (rdo[M] !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready: got %b want 1", rdo[M]); end
      end
      if (t >= 5) begin
        n_tests++; if (vo[M] !== 1'b0) begin n_fail++; $display("FAIL flush_leak_valid t=%0d: got %b want 0", t, vo[M]); end
        n_tests++; if (dout[M] === 32'hBAD) begin n_fail++; $display("FAIL flush_leak_data t=%0d: got %h want not BAD", t, dout[M]); end
      end
    end
    flush = 1'b0; vin = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      rdy = '0; vin = (t < 2); din = 32'hD0 + DW'(t);
    end
    #1;
    n_tests++; if (cnt[M] !== 8'd2) begin n_fail++; $display("FAIL areset_pre_count: got %0d want 2", cnt[M]); end
    n_tests++; if (vo[M] !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 1", vo[M]); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (vo[M] !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", vo[M]); end
    n_tests++; if (cnt[M] !== 8'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", cnt[M]); end
    n_tests++; if (eo[M] !== 1'b1) begin n_fail++; $display("FAIL areset_empty: got %b want 1", eo[M]); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(32'h1, "areset_stream");
  endtask

  // Reference: ordered list of live words with their stage position; each cycle
  // the head leaves if at the tail and ready, every other word steps forward
  // unless the word ahead of it stays put directly in front.
  logic [DW-1:0] mdat  [NI][8];
  int            mpos  [NI][8];
  int            mcnt  [NI];
  logic [DW-1:0] mlast [NI];

  task automatic test_random();
    int pv_i, rprob, vprob;
    @(negedge clk);
    rst_n = 1'b0; vin = 1'b0; flush = 1'b0; rdy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin mcnt[i] = 0; mlast[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) begin
        rprob = $urandom_range(10, 95);
        vprob = $urandom_range(10, 95);
      end
      @(negedge clk);
      vin   = ($urandom_range(0, 99) < vprob);
      din   = $urandom;
      flush = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NI; i++) rdy[i] = ($urandom_range(0, 99) < rprob);
      #1;
      for (int i = 0; i < NI; i++) begin
        int   d, k;
        int   np [8];
        logic pv, pop, pr;
        d = dep(i);
        pv = 1'b0; pop = 1'b0; pr = 1'b0;
        if (!flush) begin
          pv  = (mcnt[i] > 0) && (mpos[i][0] == d - 1);
          pop = pv && rdy[i];
          for (int j = 0; j < mcnt[i]; j++) begin
            if (j == 0) np[0] = (mpos[i][0] == d - 1) ? (pop ? -1 : d - 1) : mpos[i][0] + 1;
            else        np[j] = (np[j-1] == mpos[i][j] + 1) ? mpos[i][j] : mpos[i][j] + 1;
          end
          pr = (mcnt[i] == 0) || (np[mcnt[i]-1] != 0);
        end
        pv_i = int'(pv);
        n_tests++; if (rdo[i] !== pr) begin n_fail++; $display("FAIL rnd_ready d=%0d cyc=%0d: got %b want %b", d, cyc, rdo[i], pr); end
        n_tests++; if (vo[i] !== pv) begin n_fail++; $display("FAIL rnd_valid d=%0d cyc=%0d: got %b want %0d", d, cyc, vo[i], pv_i); end
        n_tests++; if (dout[i] !== mlast[i]) begin n_fail++; $display("FAIL rnd_data d=%0d cyc=%0d: got %h want %h", d, cyc, dout[i], mlast[i]); end
        n_tests++; if (cnt[i] !== 8'(mcnt[i])) begin n_fail++; $display("FAIL rnd_count d=%0d cyc=%0d: got %0d want %0d", d, cyc, cnt[i], mcnt[i]); end
        n_tests++; if (eo[i] !== (mcnt[i] == 0)) begin n_fail++; $display("FAIL rnd_empty d=%0d cyc=%0d: got %b want %0d", d, cyc, eo[i], mcnt[i] == 0); end
        n_tests++; if (fo[i] !== (mcnt[i] == d)) begin n_fail++; $display("FAIL rnd_full d=%0d cyc=%0d: got %b want %0d", d, cyc, fo[i], mcnt[i] == d); end
        if (flush) begin
          mcnt[i] = 0;
        end else begin
          k = 0;
          for (int j = 0; j < mcnt[i]; j++) begin
            if (np[j] >= 0) begin
              mdat[i][k] = mdat[i][j];
              mpos[i][k] = np[j];
              if (np[j] == d - 1) mlast[i] = mdat[i][j];
              k++;
            end
          end
          if (vin && pr) begin
            mdat[i][k] = din;
            mpos[i][k] = 0;
            if (d == 1) mlast[i] = din;
            k++;
          end
          mcnt[i] = k;
        end
      end
    end
    flush = 1'b0; vin = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
